// File: rtl/dec_seq.sv
// Index decoder with one-hot, thermometer and timed scan modes behind a
// valid/ready handshake; Y is registered one cycle after each accept.
module dec_seq #(
  parameter int WIDTH = 3,
  parameter int HOLD  = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [WIDTH-1:0]      W,
  input  logic                  En,
  input  logic [1:0]            Mode,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [(2**WIDTH)-1:0] Y,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic                  Busy
);

  localparam int OUT_W = 2**WIDTH;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
  localparam logic [WIDTH-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {IDLE, OUT, SCAN} state_t;

  state_t           state;
  logic [7:0]       hold_cnt;
  logic [WIDTH-1:0] scan_idx;
  logic             accept;

  function automatic logic [OUT_W-1:0] one_hot(input logic [WIDTH-1:0] i);
    logic [OUT_W-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] thermo(input logic [WIDTH-1:0] i);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int k = 0; k < OUT_W; k++) r[k] = (k <= int'(i));
    return r;
  endfunction

  // Reserved mode and any disabled request decode to all zeros.
  function automatic logic [OUT_W-1:0] decode(input logic [1:0] m, input logic e,
                                              input logic [WIDTH-1:0] i);
    logic [OUT_W-1:0] r;
    r = '0;
    if (e && m == 2'b00) r = one_hot(i);
    else if (e && m == 2'b01) r = thermo(i);
    return r;
  endfunction

  assign InReady = (state == IDLE) || (state == OUT && OutReady);
  assign accept  = InValid && InReady;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      Y        <= '0;
      OutValid <= 1'b0;
      Busy     <= 1'b0;
      hold_cnt <= '0;
      scan_idx <= '0;
    end else begin
      case (state)
        IDLE, OUT: begin
          if (accept) begin
            OutValid <= 1'b1;
            if (Mode == 2'b10 && En) begin
              state    <= SCAN;
              Busy     <= 1'b1;
              scan_idx <= W;
              hold_cnt <= '0;
              Y        <= one_hot(W);
            end else begin
              state <= OUT;
              Y     <= decode(Mode, En, W);
            end
          end else if (state == OUT && OutReady) begin
            state    <= IDLE;
            OutValid <= 1'b0;
            Y        <= '0;
          end
        end
        SCAN: begin
          // Stalled downstream freezes the whole scan, counter included.
          if (OutReady) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              if (scan_idx == IDX_LAST) begin
                state    <= IDLE;
                Busy     <= 1'b0;
                OutValid <= 1'b0;
                Y        <= '0;
              end else begin
                scan_idx <= scan_idx + 1'b1;
                Y        <= one_hot(scan_idx + 1'b1);
              end
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          Busy     <= 1'b0;
          OutValid <= 1'b0;
          Y        <= '0;
        end
      endcase
    end
  end

endmodule
